// File: rtl/spi_apb_pkg.sv
// Shared APB definitions for the SPI register bus: requester state encoding,
// default bus widths and the register map decoded by the SPI APB slave.
package spi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 3;
  localparam int unsigned APB_DATA_W = 8;

  localparam logic [2:0] ADDR_CR1 = 3'b000;
  localparam logic [2:0] ADDR_CR2 = 3'b001;
  localparam logic [2:0] ADDR_BR  = 3'b010;
  localparam logic [2:0] ADDR_SR  = 3'b011;
  localparam logic [2:0] ADDR_DR  = 3'b101;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Host command/response port and APB3 bus of the bridge, bundled in one interface.
// master = bridge side, slave = host and APB completer side.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns host commands into SETUP/ACCESS transfers, honours
// pready wait states with an optional timeout, and returns a one-cycle response.
module apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  apb_master_bridge_if.master  bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e    state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          accept, done, abort, timeout_hit;

  // Gated by reset so the host never sees a ready while the bridge is held in reset.
  assign bus.cmd_ready = preset_n && ((state == IDLE) || (state == ACCESS && bus.pready));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT));
  assign done          = (state == ACCESS) && bus.pready;
  assign abort         = (state == ACCESS) && !bus.pready && timeout_hit;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (done)       state_next = accept ? SETUP : IDLE;
        else if (abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      bus.psel      <= (state_next != IDLE);
      bus.penable   <= (state_next == ACCESS);
      bus.rsp_valid <= done || abort;

      if (accept) begin
        bus.paddr  <= bus.cmd_addr;
        bus.pwrite <= bus.cmd_write;
        bus.pwdata <= bus.cmd_wdata;
      end

      if (done) begin
        bus.rsp_err     <= bus.pslverr;
        bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
        bus.rsp_timeout <= 1'b0;
      end else if (abort) begin
        bus.rsp_err     <= 1'b1;
        bus.rsp_rdata   <= '0;
        bus.rsp_timeout <= 1'b1;
      end

      // Counts ACCESS cycles with pready low; saturates rather than wrapping.
      if (state == ACCESS && !bus.pready && !abort) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
